afe2256_lvds_align_ctrl: RTL

Training-sequence controller for the AFE2256 LVDS receive lane. It runs in the clkdiv (DCLK/4) domain between the 1:4 deserializer and the 24-bit reconstructor. On request, it steps the deserializer's bitslip until the 4-bit chunk stream matches the AFE2256 training word (12 ones followed by 12 zeros). It then reports the word (chunk) phase and drives `bit_aligned` to the reconstructor.

---
 rtl/afe2256_lvds_pkg.sv | 22 ++
 rtl/afe2256_lvds_align_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/afe2256_lvds_pkg.sv
// Shared types and training-word constants for the AFE2256 LVDS receive lane.
package afe2256_lvds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_t;

    // The training word is 12 ones then 12 zeros, i.e. six 4-bit chunks.
    localparam logic [3:0] TRAIN_HI        = 4'hF;
    localparam logic [3:0] TRAIN_LO        = 4'h0;
    localparam int         CHUNKS_PER_WORD = 6;

    function automatic logic [2:0] next_chunk_idx(input logic [2:0] idx);
        return (idx == 3'(CHUNKS_PER_WORD - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/afe2256_lvds_align_ctrl.sv
// Bitslip training controller: steps the 1:4 deserializer until the chunk stream
// matches the AFE2256 training word, then reports lock and the word phase.
module afe2256_lvds_align_ctrl
    import afe2256_lvds_pkg::*;
#(
    parameter int MATCH_CHUNKS   = 48,
    parameter int SLIP_WAIT      = 4,
    parameter int MAX_SWEEPS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       bitslip,
    output logic       bit_aligned,
    output logic       busy,
    output logic       align_error,
    output logic [1:0] slip_cnt,
    output logic [2:0] chunk_phase
);

    localparam int GOOD_W  = $clog2(MATCH_CHUNKS + 1);
    localparam int SWEEP_W = $clog2(MAX_SWEEPS + 1);
    localparam int TOUT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [GOOD_W-1:0]  GOOD_MAX  = GOOD_W'(MATCH_CHUNKS);
    localparam logic [SWEEP_W-1:0] SWEEP_MAX = SWEEP_W'(MAX_SWEEPS);
    localparam logic [TOUT_W-1:0]  TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    align_state_t       state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [TOUT_W-1:0]  tout_q, tout_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [1:0]         slip_cnt_q, slip_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         phase_q, phase_d;
    logic               phase_vld_q, phase_vld_d;
    logic               seen_hi_q, seen_hi_d;
    logic               seen_lo_q, seen_lo_d;
    logic               last_lo_q, last_lo_d;
    logic               bitslip_q, bitslip_d;
    logic               bit_aligned_q, bit_aligned_d;
    logic               busy_q, busy_d;
    logic               align_error_q, align_error_d;

    logic is_hi, is_lo, phase_err;

    assign is_hi     = (data_in == TRAIN_HI);
    assign is_lo     = (data_in == TRAIN_LO);
    // A word boundary (0 -> F) landing on a different chunk index means the stream is not the training word.
    assign phase_err = is_hi && last_lo_q && phase_vld_q && (idx_q != phase_q);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        good_d      = good_q;
        tout_d      = tout_q;
        sweep_d     = sweep_q;
        slip_cnt_d  = slip_cnt_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        phase_vld_d = phase_vld_q;
        seen_hi_d   = seen_hi_q;
        seen_lo_d   = seen_lo_q;
        last_lo_d   = last_lo_q;

        case (state_q)
            ST_SETTLE: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (data_valid) begin
                    tout_d = '0;
                    if (!(is_hi || is_lo) || phase_err) begin
                        state_d = ST_SLIP;
                    end else begin
                        good_d    = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
                        seen_hi_d = seen_hi_q | is_hi;
                        seen_lo_d = seen_lo_q | is_lo;
                        last_lo_d = is_lo;
                        idx_d     = next_chunk_idx(idx_q);
                        if (is_hi && last_lo_q && !phase_vld_q) begin
                            phase_d     = idx_q;
                            phase_vld_d = 1'b1;
                        end
                        if ((good_d == GOOD_MAX) && seen_hi_d && seen_lo_d && phase_vld_d) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end else if (tout_q == TOUT_LAST) begin
                    state_d = ST_SLIP;
                end else if (tout_q != '1) begin
                    tout_d = tout_q + TOUT_W'(1);
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 2'd1;
                state_d    = ST_SETTLE;
                if (slip_cnt_q == 2'd3) begin
                    sweep_d = sweep_q + SWEEP_W'(1);
                    if (sweep_d == SWEEP_MAX) begin
                        state_d = ST_FAIL;
                    end
                end
            end
            default: begin
            end
        endcase

        // A restart wins over anything the current state decided this cycle.
        if (start) begin
            state_d    = ST_SETTLE;
            slip_cnt_d = '0;
            sweep_d    = '0;
        end

        if (start || ((state_d == ST_SETTLE) && (state_q != ST_SETTLE))) begin
            wait_d      = '0;
            good_d      = '0;
            tout_d      = '0;
            idx_d       = '0;
            phase_d     = '0;
            phase_vld_d = 1'b0;
            seen_hi_d   = 1'b0;
            seen_lo_d   = 1'b0;
            last_lo_d   = 1'b0;
        end

        bitslip_d     = (state_d == ST_SLIP);
        busy_d        = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_SLIP);
        bit_aligned_d = (state_d == ST_LOCKED);
        align_error_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            good_q        <= '0;
            tout_q        <= '0;
            sweep_q       <= '0;
            slip_cnt_q    <= '0;
            idx_q         <= '0;
            phase_q       <= '0;
            phase_vld_q   <= 1'b0;
            seen_hi_q     <= 1'b0;
            seen_lo_q     <= 1'b0;
            last_lo_q     <= 1'b0;
            bitslip_q     <= 1'b0;
            bit_aligned_q <= 1'b0;
            busy_q        <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            good_q        <= good_d;
            tout_q        <= tout_d;
            sweep_q       <= sweep_d;
            slip_cnt_q    <= slip_cnt_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            phase_vld_q   <= phase_vld_d;
            seen_hi_q     <= seen_hi_d;
            seen_lo_q     <= seen_lo_d;
            last_lo_q     <= last_lo_d;
            bitslip_q     <= bitslip_d;
            bit_aligned_q <= bit_aligned_d;
            busy_q        <= busy_d;
            align_error_q <= align_error_d;
        end
    end

    assign bitslip     = bitslip_q;
    assign bit_aligned = bit_aligned_q;
    assign busy        = busy_q;
    assign align_error = align_error_q;
    assign slip_cnt    = slip_cnt_q;
    assign chunk_phase = phase_q;

endmodule
